// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback data path: load extraction, source select, GPR write gating.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic        Valid_M,
    input  logic        Exc_M,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC_M,
    input  logic [4:0]  WA_M,
    input  logic        RegWrite_M,
    input  logic [2:0]  WDSel_M,
    input  logic [2:0]  LdType_M,
    input  logic [1:0]  ByteOff_M,
    input  logic [31:0] ALUOut_M,
    input  logic [31:0] DMRD_M,
    input  logic [31:0] HILO_M,
    input  logic [31:0] CP0RD_M,
    output logic [31:0] IR_W,
    output logic [31:0] PC_W,
    output logic [4:0]  WA,
    output logic [31:0] WD,
    output logic        RegWrite,
    output logic        Valid_W,
    output logic [31:0] RetireCnt
);

    logic        regwrite_r;
    logic [2:0]  wdsel_r;
    logic [2:0]  ldtype_r;
    logic [1:0]  byteoff_r;
    logic [31:0] aluout_r;
    logic [31:0] dmrd_r;
    logic [31:0] hilo_r;
    logic [31:0] cp0rd_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IR_W       <= '0;
            PC_W       <= RESET_PC;
            WA         <= '0;
            Valid_W    <= 1'b0;
            regwrite_r <= 1'b0;
            wdsel_r    <= '0;
            ldtype_r   <= '0;
            byteoff_r  <= '0;
            aluout_r   <= '0;
            dmrd_r     <= '0;
            hilo_r     <= '0;
            cp0rd_r    <= '0;
        end else if (flush) begin
            IR_W       <= '0;
            PC_W       <= RESET_PC;
            WA         <= '0;
            Valid_W    <= 1'b0;
            regwrite_r <= 1'b0;
            wdsel_r    <= '0;
            ldtype_r   <= '0;
            byteoff_r  <= '0;
            aluout_r   <= '0;
            dmrd_r     <= '0;
            hilo_r     <= '0;
            cp0rd_r    <= '0;
        end else if (en) begin
            IR_W       <= IR_M;
            PC_W       <= PC_M;
            WA         <= WA_M;
            Valid_W    <= Valid_M & ~Exc_M;
            regwrite_r <= RegWrite_M;
            wdsel_r    <= WDSel_M;
            ldtype_r   <= LdType_M;
            byteoff_r  <= ByteOff_M;
            aluout_r   <= ALUOut_M;
            dmrd_r     <= DMRD_M;
            hilo_r     <= HILO_M;
            cp0rd_r    <= CP0RD_M;
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = dmrd_r[7:0];
        case (byteoff_r)
            2'd1:    ld_byte = dmrd_r[15:8];
            2'd2:    ld_byte = dmrd_r[23:16];
            2'd3:    ld_byte = dmrd_r[31:24];
            default: ld_byte = dmrd_r[7:0];
        endcase
        ld_half = byteoff_r[1] ? dmrd_r[31:16] : dmrd_r[15:0];
        case (ldtype_r)
            3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    ld_data = {24'h0, ld_byte};
            3'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {16'h0, ld_half};
            default: ld_data = dmrd_r;
        endcase
    end

    always_comb begin
        case (wdsel_r)
            3'd0:    WD = aluout_r;
            3'd1:    WD = ld_data;
            3'd2:    WD = PC_W + 32'd8;
            3'd3:    WD = hilo_r;
            3'd4:    WD = cp0rd_r;
            default: WD = '0;
        endcase
    end

    // $0 is hardwired zero, so a write to it is dropped here
    assign RegWrite = regwrite_r & Valid_W & (WA != 5'd0);

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_q <= '0;
        end else if (!flush && en && Valid_M && !Exc_M) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign RetireCnt = retire_q;
`else
    assign RetireCnt = 32'h0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomised and directed bench for wb_stage against a snapshot-based writeback model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        Valid_M = 1'b0;
    logic        Exc_M = 1'b0;
    logic [31:0] IR_M = '0;
    logic [31:0] PC_M = '0;
    logic [4:0]  WA_M = '0;
    logic        RegWrite_M = 1'b0;
    logic [2:0]  WDSel_M = '0;
    logic [2:0]  LdType_M = '0;
    logic [1:0]  ByteOff_M = '0;
    logic [31:0] ALUOut_M = '0;
    logic [31:0] DMRD_M = '0;
    logic [31:0] HILO_M = '0;
    logic [31:0] CP0RD_M = '0;
    logic [31:0] IR_W;
    logic [31:0] PC_W;
    logic [4:0]  WA;
    logic [31:0] WD;
    logic        RegWrite;
    logic        Valid_W;
    logic [31:0] RetireCnt;

    wb_stage dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .Valid_M(Valid_M), .Exc_M(Exc_M), .IR_M(IR_M), .PC_M(PC_M),
        .WA_M(WA_M), .RegWrite_M(RegWrite_M), .WDSel_M(WDSel_M),
        .LdType_M(LdType_M), .ByteOff_M(ByteOff_M), .ALUOut_M(ALUOut_M),
        .DMRD_M(DMRD_M), .HILO_M(HILO_M), .CP0RD_M(CP0RD_M),
        .IR_W(IR_W), .PC_W(PC_W), .WA(WA), .WD(WD), .RegWrite(RegWrite),
        .Valid_W(Valid_W), .RetireCnt(RetireCnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: snapshot of the instruction sitting in W
    logic [31:0] m_ir, m_pc, m_alu, m_dm, m_hilo, m_cp0, m_cnt;
    logic [4:0]  m_wa;
    logic        m_valid, m_rw;
    logic [2:0]  m_sel, m_ld;
    logic [1:0]  m_off;

    always @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            m_ir <= 0; m_pc <= 32'h3000; m_wa <= 0; m_valid <= 0; m_rw <= 0;
            m_sel <= 0; m_ld <= 0; m_off <= 0; m_alu <= 0; m_dm <= 0;
            m_hilo <= 0; m_cp0 <= 0;
            if (!reset) m_cnt <= 0;
        end else if (en) begin
            m_ir <= IR_M; m_pc <= PC_M; m_wa <= WA_M;
            m_valid <= Valid_M && !Exc_M; m_rw <= RegWrite_M;
            m_sel <= WDSel_M; m_ld <= LdType_M; m_off <= ByteOff_M;
            m_alu <= ALUOut_M; m_dm <= DMRD_M; m_hilo <= HILO_M; m_cp0 <= CP0RD_M;
`ifdef WB_RETIRE_CNT_EN
            if (Valid_M && !Exc_M) m_cnt <= m_cnt + 1;
`endif
        end
    end

    function automatic logic [31:0] load_val(input logic [2:0] ld,
                                             input logic [1:0] off,
                                             input logic [31:0] dm);
        logic [31:0] b, h;
        b = (dm >> (8 * off)) & 32'hFF;
        h = (dm >> (16 * (off / 2))) & 32'hFFFF;
        case (ld)
            3'd1: return (b >= 128) ? b - 256 : b;
            3'd2: return b;
            3'd3: return (h >= 32768) ? h - 65536 : h;
            3'd4: return h;
            default: return dm;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd();
        case (m_sel)
            3'd0: return m_alu;
            3'd1: return load_val(m_ld, m_off, m_dm);
            3'd2: return m_pc + 8;
            3'd3: return m_hilo;
            3'd4: return m_cp0;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        chk("IR_W", IR_W, m_ir);
        chk("PC_W", PC_W, m_pc);
        chk("WA", {27'h0, WA}, {27'h0, m_wa});
        chk("WD", WD, exp_wd());
        chk("RegWrite", {31'h0, RegWrite}, {31'h0, m_rw && m_valid && m_wa != 0});
        chk("Valid_W", {31'h0, Valid_W}, {31'h0, m_valid});
        chk("RetireCnt", RetireCnt, m_cnt);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [4:0] wa, input logic [2:0] sel,
                             input logic [2:0] ld, input logic [1:0] off);
        en = 1; flush = 0; Valid_M = 1; Exc_M = 0; RegWrite_M = 1;
        WA_M = wa; WDSel_M = sel; LdType_M = ld; ByteOff_M = off;
    endtask

    typedef struct { logic [2:0] ld; logic [1:0] off; logic [31:0] exp; } ld_vec_t;
    ld_vec_t lv[5];
    logic [31:0] sv_ir, sv_pc, sv_wd, sv_cnt;
    int exp_cnt;

    initial begin
        lv[0] = '{3'd1, 2'd3, 32'hFFFF_FF80};
        lv[1] = '{3'd2, 2'd3, 32'h0000_0080};
        lv[2] = '{3'd3, 2'd2, 32'hFFFF_80FF};
        lv[3] = '{3'd4, 2'd3, 32'h0000_80FF};
        lv[4] = '{3'd1, 2'd0, 32'h0000_0001};

        @(negedge clk); @(negedge clk);
        chk("rst_IR_W", IR_W, 32'h0);
        chk("rst_PC_W", PC_W, 32'h3000);
        chk("rst_WD", WD, 32'h0);
        chk("rst_RegWrite", {31'h0, RegWrite}, 32'h0);
        chk("rst_RetireCnt", RetireCnt, 32'h0);
        reset = 1;

        set_instr(5'd5, 3'd0, 3'd0, 2'd0);
        ALUOut_M = 32'h1234_5678; PC_M = 32'h3004; IR_M = 32'h2345_0001;
        step();
        chk("alu_WA", {27'h0, WA}, 32'd5);
        chk("alu_WD", WD, 32'h1234_5678);
        chk("alu_RegWrite", {31'h0, RegWrite}, 32'h1);
        chk("alu_PC_W", PC_W, 32'h3004);

        DMRD_M = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            set_instr(5'd3, 3'd1, lv[i].ld, lv[i].off);
            step();
            chk($sformatf("load%0d_WD", i), WD, lv[i].exp);
        end

        sv_cnt = RetireCnt;
        set_instr(5'd8, 3'd0, 3'd0, 2'd0);
        Exc_M = 1;
        step();
        chk("exc_RegWrite", {31'h0, RegWrite}, 32'h0);
        chk("exc_Valid_W", {31'h0, Valid_W}, 32'h0);
        chk("exc_RetireCnt", RetireCnt, sv_cnt);
        set_instr(5'd0, 3'd0, 3'd0, 2'd0);
        step();
        chk("r0_RegWrite", {31'h0, RegWrite}, 32'h0);

        set_instr(5'd9, 3'd0, 3'd0, 2'd0);
        IR_M = 32'hABCD_0123; PC_M = 32'h3040; ALUOut_M = 32'h5555_AAAA;
        step();
        sv_ir = IR_W; sv_pc = PC_W; sv_wd = WD;
        en = 0;
        for (int i = 0; i < 3; i++) begin
            IR_M = $urandom; PC_M = $urandom; ALUOut_M = $urandom;
            step();
            chk("stall_IR_W", IR_W, 32'hABCD_0123);
            chk("stall_WD", WD, 32'h5555_AAAA);
        end
        chk("stall_PC_W", PC_W, sv_pc);
        flush = 1;
        step();
        flush = 0;
        chk("flush_IR_W", IR_W, 32'h0);
        chk("flush_PC_W", PC_W, 32'h3000);
        chk("flush_RegWrite", {31'h0, RegWrite}, 32'h0);

        set_instr(5'd31, 3'd2, 3'd0, 2'd0);
        PC_M = 32'h0000_3010;
        step();
        chk("pc8_WD", WD, 32'h0000_3018);
        PC_M = 32'hFFFF_FFFC;
        step();
        chk("pc8wrap_WD", WD, 32'h0000_0004);

        @(posedge clk);
        #2 reset = 0;
        #1;
        chk("async_IR_W", IR_W, 32'h0);
        chk("async_PC_W", PC_W, 32'h3000);
        chk("async_WD", WD, 32'h0);
        chk("async_RetireCnt", RetireCnt, 32'h0);
        @(negedge clk);
        reset = 1;

        set_instr(5'd4, 3'd0, 3'd0, 2'd0);
        for (int i = 0; i < 10; i++) step();
        Exc_M = 1;
        for (int i = 0; i < 2; i++) step();
        Exc_M = 0; flush = 1;
        step();
        flush = 0; en = 0;
        for (int i = 0; i < 3; i++) step();
`ifdef WB_RETIRE_CNT_EN
        exp_cnt = 10;
`else
        exp_cnt = 0;
`endif
        chk("retire_total", RetireCnt, exp_cnt);

        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            Valid_M = ($urandom_range(0, 5) != 0);
            Exc_M = ($urandom_range(0, 7) == 0);
            RegWrite_M = $urandom;
            WA_M = $urandom;
            WDSel_M = $urandom;
            LdType_M = $urandom;
            ByteOff_M = $urandom;
            IR_M = $urandom;
            PC_M = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            ALUOut_M = $urandom;
            DMRD_M = $urandom;
            HILO_M = $urandom;
            CP0RD_M = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
